alu_pipe: RTL and testbench

Parametrised successor to the two-stage add/sub datapath block: a pipelined integer ALU with valid/ready handshakes on both sides, a full logic/shift/compare op set, status flags, and an iterative multi-cycle multiply. It sits between an issuing front end and a result consumer, and sustains one single-cycle op per clock under no backpressure.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_pipe_if.sv | 16 +
 rtl/alu_mul_seq.sv | 39 +++
 rtl/alu_pipe.sv | 106 ++++++++++
 tb/tb_alu_pipe.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, execute states and flag bit positions for alu_pipe
package alu_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } operation_t;
  typedef enum logic {IDLE, MUL} exec_state_t;
  localparam int ZERO  = 0;
  localparam int CARRY = 1;
  localparam int OVF   = 2;
  localparam int ERR   = 3;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request and result valid/ready channels of alu_pipe
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic [3:0]       op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic [3:0]       flags;
  logic             out_valid;
  logic             out_ready;
  modport master (output op_in, a_in, b_in, in_valid, out_ready,
                  input  in_ready, out, flags, out_valid);
  modport slave  (input  op_in, a_in, b_in, in_valid, out_ready,
                  output in_ready, out, flags, out_valid);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: radix-2 shift-add multiplier, one multiplier bit per cycle
module alu_mul_seq #(parameter int WIDTH = 8) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  assign busy = cnt != '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      done   <= 1'b0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      done   <= 1'b0;
    end else if (busy) begin
      prod   <= mplier[0] ? prod + mcand : prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - ONE;
      done   <= cnt == ONE;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU with flags and iterative multiply
module alu_pipe
  import alu_pkg::*;
#(parameter int WIDTH = 8) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  logic               s1_valid, s1_done, slot_free, is_sub;
  logic               mul_start, mul_busy, mul_done;
  logic [3:0]         s1_op, alu_fl, fl;
  logic [WIDTH-1:0]   s1_a, s1_b, bx, alu_res, res;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  exec_state_t        state, state_n;
  assign slot_free    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s1_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      s1_valid <= 1'b1;
      s1_op    <= bus.op_in;
      s1_a     <= bus.a_in;
      s1_b     <= bus.b_in;
    end else if (s1_done) begin
      s1_valid <= 1'b0;
    end
  end
  // sub shares the adder: a + ~b + 1, so carry-out means "no borrow"
  always_comb begin
    is_sub  = s1_op == OP_SUB;
    bx      = is_sub ? ~s1_b : s1_b;
    sum     = {1'b0, s1_a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    alu_res = '0;
    alu_fl  = '0;
    case (s1_op)
      OP_NOP, OP_MUL: ;
      OP_ADD, OP_SUB: begin
        alu_res       = sum[WIDTH-1:0];
        alu_fl[CARRY] = sum[WIDTH];
        alu_fl[OVF]   = (s1_a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  alu_res = s1_a & s1_b;
      OP_OR:   alu_res = s1_a | s1_b;
      OP_XOR:  alu_res = s1_a ^ s1_b;
      OP_SLL:  alu_res = s1_a << s1_b[SHW-1:0];
      OP_SRL:  alu_res = s1_a >> s1_b[SHW-1:0];
      OP_SRA:  alu_res = $signed(s1_a) >>> s1_b[SHW-1:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, s1_a < s1_b};
      default: alu_fl[ERR] = 1'b1;
    endcase
    alu_fl[ZERO] = s1_op != OP_NOP && s1_op <= OP_SLTU && alu_res == '0;
  end
  assign res = state == MUL ? prod[WIDTH-1:0] : alu_res;
  assign fl  = state == MUL ? {2'b00, |prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:0] == '0} : alu_fl;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (s1_a),
    .b     (s1_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (prod)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n   = state;
    s1_done   = 1'b0;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        mul_start = s1_valid && s1_op == OP_MUL;
        s1_done   = s1_valid && s1_op != OP_MUL && slot_free;
        state_n   = mul_start ? MUL : IDLE;
      end
      MUL: begin
        s1_done = mul_done && !mul_busy && slot_free;
        state_n = s1_done ? IDLE : MUL;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out       <= '0;
      bus.flags     <= '0;
      bus.out_valid <= 1'b0;
    end else if (s1_done) begin
      bus.out       <= res;
      bus.flags     <= fl;
      bus.out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand sequences for multiply, streaming, backpressure, reset
module tb_alu_pipe;
  import alu_pkg::*;
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [3:0] f;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ncmp = 0;
  int nfail = 0;
  bit rec_en = 1'b0;
  logic [7:0] recq[$];
  vec_t vt[19];
  alu_pipe_if #(.WIDTH(8)) bus();
  alu_pipe #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #2;
    if (rec_en && bus.out_valid && bus.out_ready) recq.push_back(bus.out);
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    bus.op_in = op;
    bus.a_in = a;
    bus.b_in = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      ncmp++;
      nfail++;
      $display("FAIL send_timeout: in_ready got 0 for 50 cycles required 1");
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  initial begin
    vt = '{
      '{OP_NOP,  8'h00, 8'h00, 8'h00, 4'b0000},
      '{OP_ADD,  8'hFF, 8'h01, 8'h00, 4'b0011},
      '{OP_ADD,  8'h7F, 8'h01, 8'h80, 4'b0100},
      '{OP_ADD,  8'h80, 8'h80, 8'h00, 4'b0111},
      '{OP_SUB,  8'h80, 8'h01, 8'h7F, 4'b0110},
      '{OP_SUB,  8'h01, 8'h02, 8'hFF, 4'b0000},
      '{OP_SUB,  8'h05, 8'h05, 8'h00, 4'b0011},
      '{OP_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000},
      '{OP_OR,   8'hF0, 8'h0F, 8'hFF, 4'b0000},
      '{OP_XOR,  8'hAA, 8'hAA, 8'h00, 4'b0001},
      '{OP_SLL,  8'h81, 8'h09, 8'h02, 4'b0000},
      '{OP_SRL,  8'h80, 8'h07, 8'h01, 4'b0000},
      '{OP_SRA,  8'h80, 8'h03, 8'hF0, 4'b0000},
      '{OP_SRA,  8'h40, 8'h02, 8'h10, 4'b0000},
      '{OP_SLT,  8'h80, 8'h01, 8'h01, 4'b0000},
      '{OP_SLT,  8'h01, 8'h80, 8'h00, 4'b0001},
      '{OP_SLTU, 8'h80, 8'h01, 8'h00, 4'b0001},
      '{4'hE,    8'h12, 8'h34, 8'h00, 4'b1000},
      '{4'hF,    8'h05, 8'h05, 8'h00, 4'b1000}
    };
    bus.op_in = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out", bus.out, 0);
    chk("reset_flags", bus.flags, 0);
    chk("reset_out_valid", bus.out_valid, 0);
    foreach (vt[i]) begin
      send(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d_not_early", i), bus.out_valid, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d_out", i), bus.out, vt[i].r);
      chk($sformatf("vec%0d_flags", i), bus.flags, vt[i].f);
    end
    @(negedge clk);
    send(OP_MUL, 8'd13, 8'd11);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("mul_busy_ready_%0d", k), bus.in_ready, 0);
      chk($sformatf("mul_busy_valid_%0d", k), bus.out_valid, 0);
      @(negedge clk);
    end
    chk("mul_free_ready", bus.in_ready, 1);
    chk("mul_not_early", bus.out_valid, 0);
    @(negedge clk);
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_out", bus.out, 8'h8F);
    chk("mul_flags", bus.flags, 4'b0000);
    @(negedge clk);
    send(OP_MUL, 8'h10, 8'h10);
    repeat (9) @(negedge clk);
    @(negedge clk);
    chk("mul_hi_valid", bus.out_valid, 1);
    chk("mul_hi_out", bus.out, 8'h00);
    chk("mul_hi_flags", bus.flags, 4'b0011);
    @(negedge clk);
    for (int c = 0; c < 18; c++) begin
      if (c >= 2) begin
        chk($sformatf("stream_valid_%0d", c - 2), bus.out_valid, 1);
        chk($sformatf("stream_out_%0d", c - 2), bus.out, 8'((c - 2) * 5 + (c - 2) + 7));
      end
      if (c < 16) begin
        chk($sformatf("stream_ready_%0d", c), bus.in_ready, 1);
        bus.op_in = OP_ADD;
        bus.a_in = 8'(c * 5);
        bus.b_in = 8'(c + 7);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("stream_drained", bus.out_valid, 0);
    recq.delete();
    rec_en = 1'b1;
    bus.out_ready = 1'b0;
    bus.op_in = OP_ADD;
    bus.a_in = 8'd1;
    bus.b_in = 8'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_s1_only", bus.in_ready, 1);
    bus.a_in = 8'd2;
    bus.b_in = 8'd2;
    @(negedge clk);
    chk("bp_full_valid", bus.out_valid, 1);
    chk("bp_full_out", bus.out, 8'd2);
    chk("bp_full_ready", bus.in_ready, 0);
    bus.a_in = 8'd3;
    bus.b_in = 8'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_out_%0d", k), bus.out, 8'd2);
      chk($sformatf("bp_hold_flags_%0d", k), bus.flags, 4'b0000);
      chk($sformatf("bp_hold_ready_%0d", k), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp_second_out", bus.out, 8'd4);
    @(negedge clk);
    chk("bp_third_out", bus.out, 8'd6);
    @(negedge clk);
    chk("bp_drained", bus.out_valid, 0);
    rec_en = 1'b0;
    chk("bp_count", recq.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_order_%0d", i), i < recq.size() ? recq[i] : 8'hxx, 8'(2 * i + 2));
    send(OP_MUL, 8'd5, 8'd6);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mul_valid", bus.out_valid, 0);
    chk("rst_mul_ready", bus.in_ready, 1);
    chk("rst_mul_flags", bus.flags, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("rst_mul_no_result", seen, 0);
    end
    send(OP_ADD, 8'd3, 8'd4);
    chk("post_rst_not_early", bus.out_valid, 0);
    @(negedge clk);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_out", bus.out, 8'd7);
    chk("post_rst_flags", bus.flags, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
